// File: rtl/iddr_word_align.sv
// iddr_word_align: assembles DDR bit pairs into W-bit words and bit-slips to lock on a training word.
// Define IDDR_WORD_ALIGN_STATS_EN to add the err_total and relock_cnt statistics outputs.
module iddr_word_align #(
  parameter int W        = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_MAX  = 3,
  parameter int SETTLE   = 1
) (
  input  logic                 c,
  input  logic                 rst_n,
  input  logic [1:0]           d,
  input  logic                 train_en,
  input  logic [W-1:0]         pattern,
  input  logic                 realign,
  output logic [W-1:0]         q,
  output logic                 q_valid,
  output logic                 locked,
  output logic [$clog2(W)-1:0] slip
`ifdef IDDR_WORD_ALIGN_STATS_EN
  ,
  output logic [15:0]          err_total,
  output logic [7:0]           relock_cnt
`endif
);

  localparam int SW = $clog2(W);
  localparam int PW = $clog2(W/2);
  localparam logic [PW-1:0] PH_LAST = PW'(W/2-1);
  localparam logic [SW-1:0] SL_LAST = SW'(W-1);
  localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0] ERR_C  = 8'(ERR_MAX);
  localparam logic [7:0] SET_C  = 8'(SETTLE);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t          st_q, st_d;
  logic [2*W-1:0]  h_q, h_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [W-1:0]    word_q, word_d;
  logic            vld_q;
  logic            lock_q, lock_d;
  logic [SW-1:0]   slip_q, slip_d, slip_inc;
  logic [7:0]      mcnt_q, mcnt_d;
  logic [7:0]      ecnt_q, ecnt_d;
  logic [7:0]      set_q, set_d;
  logic            strobe, hit, cmp;
  logic            err_hit, drop;
  logic            unused_h;

  // Shift register keeps the earlier bit above the later one.
  assign h_d      = {h_q[2*W-3:0], d[0], d[1]};
  assign strobe   = (ph_q == PH_LAST);
  assign ph_d     = strobe ? '0 : ph_q + PW'(1);
  assign word_d   = h_d[slip_q +: W];
  assign hit      = (word_d == pattern);
  assign cmp      = strobe & train_en & (set_q == 8'd0);
  assign slip_inc = (slip_q == SL_LAST) ? '0 : slip_q + SW'(1);
  assign unused_h = ^{h_q[2*W-1 -: 2], h_d[2*W-1]};

  // Capture history, word phase and the extracted word.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      ph_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      ph_q  <= ph_d;
      vld_q <= strobe;
      if (strobe) word_q <= word_d;
    end
  end

  // Alignment state, slip offset and counters.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= HUNT;
      lock_q <= 1'b0;
      slip_q <= '0;
      mcnt_q <= '0;
      ecnt_q <= '0;
      set_q  <= '0;
    end else begin
      st_q   <= st_d;
      lock_q <= lock_d;
      slip_q <= slip_d;
      mcnt_q <= mcnt_d;
      ecnt_q <= ecnt_d;
      set_q  <= set_d;
    end
  end

  // Hunt / verify / locked transitions; realign overrides any compare.
  always_comb begin
    st_d    = st_q;
    lock_d  = lock_q;
    slip_d  = slip_q;
    mcnt_d  = mcnt_q;
    ecnt_d  = ecnt_q;
    set_d   = set_q;
    err_hit = 1'b0;
    drop    = 1'b0;
    if (strobe && train_en && set_q != 8'd0) set_d = set_q - 8'd1;
    if (cmp) begin
      unique case (st_q)
        HUNT: begin
          if (hit) begin
            st_d   = VERIFY;
            mcnt_d = 8'd1;
            if (LOCK_C == 8'd1) begin
              st_d   = LOCKED;
              lock_d = 1'b1;
              mcnt_d = 8'd0;
            end
          end else begin
            slip_d = slip_inc;
            set_d  = SET_C;
          end
        end
        VERIFY: begin
          if (hit) begin
            mcnt_d = mcnt_q + 8'd1;
            if (mcnt_d == LOCK_C) begin
              st_d   = LOCKED;
              lock_d = 1'b1;
              mcnt_d = 8'd0;
            end
          end else begin
            st_d   = HUNT;
            slip_d = slip_inc;
            set_d  = SET_C;
            mcnt_d = 8'd0;
          end
        end
        LOCKED: begin
          if (hit) begin
            ecnt_d = 8'd0;
          end else begin
            err_hit = 1'b1;
            ecnt_d  = ecnt_q + 8'd1;
            if (ecnt_d == ERR_C) begin
              st_d   = HUNT;
              lock_d = 1'b0;
              ecnt_d = 8'd0;
              drop   = 1'b1;
            end
          end
        end
        default: st_d = HUNT;
      endcase
    end
    if (realign) begin
      st_d    = HUNT;
      lock_d  = 1'b0;
      slip_d  = slip_q;
      mcnt_d  = 8'd0;
      ecnt_d  = 8'd0;
      set_d   = 8'd0;
      err_hit = 1'b0;
      drop    = (st_q == LOCKED);
    end
  end

  assign q       = word_q;
  assign q_valid = vld_q;
  assign locked  = lock_q;
  assign slip    = slip_q;

`ifdef IDDR_WORD_ALIGN_STATS_EN
  logic [15:0] et_q;
  logic [7:0]  rc_q;

  // Saturating error and lock-loss statistics.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      et_q <= '0;
      rc_q <= '0;
    end else begin
      if (err_hit && et_q != 16'hFFFF) et_q <= et_q + 16'd1;
      if (drop && rc_q != 8'hFF) rc_q <= rc_q + 8'd1;
    end
  end

  assign err_total  = et_q;
  assign relock_cnt = rc_q;
`else
  logic unused_stats;
  assign unused_stats = err_hit ^ drop;
`endif

endmodule
